// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between instruction fetch and load/store, with starvation guard.
// Optional byte load/store support (read-modify-write) is compiled in with `define MEM_ARB_BYTE_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] ram_ad,
  output logic [31:0] ram_d,
  output logic        ram_we,
  input  logic [31:0] ram_q
);

  localparam int unsigned FULLW = 32;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNTW-1:0] starve_cnt;
  logic            in_rmw;
  logic            byte_op;
  logic            data_wins;

`ifdef MEM_ARB_BYTE_EN
  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t           state;
  logic [FULLW-1:0] rmw_addr;
  logic [WIDTH-1:0] rmw_byte;
  logic             d_byte_q;

  assign in_rmw  = (state == RMW_WR);
  assign byte_op = d_byte;
`else
  logic unused_d_byte;

  assign unused_d_byte = d_byte;
  assign in_rmw        = 1'b0;
  assign byte_op       = 1'b0;
`endif

  // Grant and RAM drive; everything is forced low while reset is asserted.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    ram_ad    = '0;
    ram_d     = '0;
    ram_we    = 1'b0;
    data_wins = d_req && !(if_req && (starve_cnt == CNTW'(STARVE_LIMIT)));
    if (rst_n && !in_rmw) begin
      if (data_wins) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
    if (d_gnt) begin
      ram_ad = d_addr;
      if (d_we && !byte_op) begin
        ram_we = 1'b1;
        ram_d  = d_wdata;
      end
    end else if (if_gnt) begin
      ram_ad = if_addr;
    end
`ifdef MEM_ARB_BYTE_EN
    // Merge the latched byte into the word read back during the grant cycle.
    if (rst_n && in_rmw) begin
      ram_ad = rmw_addr;
      ram_we = 1'b1;
      ram_d  = {rmw_byte, ram_q[FULLW-WIDTH-1:0]};
    end
`endif
  end

  // Read data is only presented alongside its valid strobe.
  always_comb begin
    if_rdata = '0;
    d_rdata  = '0;
    if (if_rvalid) begin
      if_rdata = ram_q;
    end
    if (d_rvalid) begin
`ifdef MEM_ARB_BYTE_EN
      if (d_byte_q) begin
        d_rdata = FULLW'(ram_q[FULLW-1 -: WIDTH]);
      end else begin
        d_rdata = ram_q;
      end
`else
      d_rdata = ram_q;
`endif
    end
  end

  // Sequencer state, starvation counter and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
`ifdef MEM_ARB_BYTE_EN
      state      <= IDLE;
      rmw_addr   <= '0;
      rmw_byte   <= '0;
      d_byte_q   <= 1'b0;
`endif
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt && !d_we;
      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != CNTW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CNTW'(1);
      end
`ifdef MEM_ARB_BYTE_EN
      d_byte_q <= d_gnt && !d_we && d_byte;
      case (state)
        IDLE: begin
          if (d_gnt && d_we && d_byte) begin
            state    <= RMW_WR;
            rmw_addr <= d_addr;
            rmw_byte <= d_wdata[WIDTH-1:0];
          end
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
`endif
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-cycle arbiter and sequencer that shares the single-port, byte-addressed, word-wide data RAM between the CPU instruction-fetch port and the load/store port. It sits between the core and `ram`. It drives `ram`'s `d`/`ad`/`we` and consumes its registered `q` (one-cycle read latency, big-endian byte order). It also converts byte stores into a read-modify-write sequence when byte support is compiled in.

## Interface
Parameters:
- `STARVE_LIMIT`, default 2: consecutive data-port grants allowed while `if_req` is pending before fetch is forced to win.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `rst_n` in 1: asynchronous reset, active-low.
- `if_req` in 1: fetch request (read-only).
- `if_addr` in `FULLW`: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out `FULLW`: fetch word.
- `d_req` in 1: load/store request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_byte` in 1: byte access (only honoured with `MEM_ARB_BYTE_EN`).
- `d_addr` in `FULLW`: data byte address.
- `d_wdata` in `FULLW`: store data; for byte stores, `d_wdata[7:0]`.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out `FULLW`: load word, or zero-extended byte.
- `ram_ad` out `FULLW`: to `ram.ad`.
- `ram_d` out `FULLW`: to `ram.d`.
- `ram_we` out 1: to `ram.we`.
- `ram_q` in `FULLW`: from `ram.q`; valid the cycle after the address is presented.

## Operation
- State machine with two states:
  - IDLE: normal arbitration.
  - RMW_WR: second cycle of a byte store.
- Arbitration in IDLE (combinational grant):
  - Only one requester: it is granted.
  - Both requesting: data wins unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- `starve_cnt`:
  - Increments on a data grant while `if_req` = 1.
  - Clears on any fetch grant or when `if_req` = 0.
  - Saturates at `STARVE_LIMIT`.
- Grant cycle RAM drive:
  - `ram_ad` = granted address.
  - Word store: `ram_we` = 1 and `ram_d` = `d_wdata`.
  - Load and fetch: `ram_we` = 0.
- Read return: `if_rvalid`/`d_rvalid` are registered and assert exactly one cycle after the read grant. `*_rdata` = `ram_q` when the matching rvalid = 1, else 0.
- Stores produce no rvalid; `d_gnt` is their completion.
- Byte load: `d_rdata` = {zeros, `ram_q[FULLW-1 -: WIDTH]`}. Byte 0 at the address is the MSB byte.
- Byte store: a two-cycle sequence.
  - Grant cycle: read at `d_addr` (`ram_we` = 0); latch the address and `d_wdata[7:0]`; go to RMW_WR.
  - RMW_WR: `ram_ad` = latched address, `ram_we` = 1, `ram_d` = {latched byte, `ram_q[FULLW-WIDTH-1:0]`}; no grants; return to IDLE.
- Reset: state IDLE, `starve_cnt` = 0, both rvalid = 0. As a consequence, all gnt, rvalid, rdata and `ram_we` outputs are 0.
- Reset asserted mid-RMW: the write is suppressed immediately (`ram_we` drops asynchronously) and the pending rvalid is dropped. No partial write is allowed.

## Timing
- Grant: 0-cycle; `*_gnt` is combinational from `*_req` and state.
- Load/fetch latency: 1 cycle from grant to rvalid.
- Back-to-back reads: fully pipelined, one grant per cycle, no bubbles.
- Word store: occupies 1 cycle.
- Byte store: occupies 2 cycles. Any request presented during RMW_WR sees gnt = 0 and must hold its request.
- Requesters hold `req`/address/data stable until gnt.
- Read-after-write to the same address in the next cycle returns the new data, because RAM writes land at the posedge of the grant cycle.

## Configuration
- `MEM_ARB_BYTE_EN` defined:
  - `d_byte` is honoured.
  - RMW_WR state, latch registers and byte-extract logic are compiled in.
- Not defined:
  - `d_byte` is ignored, and every data access is a full word.
  - The state machine reduces to IDLE only.
  - Byte stores write the full word `d_wdata`.

## Test plan
- Fetch-only stream: `if_addr` = 0,4,8 on consecutive cycles, RAM preloaded. Expect `if_gnt` = 1 each cycle, `if_rvalid` one cycle later each time, and `if_rdata` = the preloaded words, with no bubbles.
- Contention: `if_req` and `d_req` (loads) both held for 6 cycles with `STARVE_LIMIT` = 2. Expect the grant order D,D,F,D,D,F.
- Word store then load: store 0xDEADBEEF to 0x10, then load 0x10 on the next cycle. Expect `d_rdata` = 0xDEADBEEF with `d_rvalid` one cycle after the load grant.
- Byte store (macro on): word 0x11223344 at 0x20; byte-store 0xAA to 0x20. Expect 2 busy cycles with `if_gnt` held 0, then a word read at 0x20 = 0xAA223344. A byte load at 0x20 returns 0x000000AA.
- Macro off: the same byte store writes the full word, so a read at 0x20 returns `d_wdata` = 0x000000AA.
- Reset mid-RMW: assert `rst_n` = 0 during RMW_WR. Expect `ram_we` = 0 immediately, the word at 0x20 unchanged, and all outputs 0 until release.
